// File: rtl/scoreboard_register_file_pkg.sv
// Shared cpu package: default word/register-file geometry and helpers for scoreboard_register_file.
package scoreboard_register_file_pkg;

  localparam int unsigned WORD_W_DEF       = 32;
  localparam int unsigned NREGS_DEF        = 32;
  localparam int unsigned NREAD_DEF        = 2;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;
  localparam int unsigned SEL_W_DEF        = $clog2(NREGS_DEF);

  typedef logic [WORD_W_DEF-1:0] word_t;
  typedef logic [SEL_W_DEF-1:0]  regbits_t;

  // Width of a pending counter able to hold 0..max_inflight.
  function automatic int unsigned cnt_width(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Saturating up/down pending-reservation counter, one per architectural register.
module rf_pend_counter
  import scoreboard_register_file_pkg::*;
#(
  parameter  int unsigned MAX   = MAX_INFLIGHT_DEF,
  localparam int unsigned CNT_W = cnt_width(MAX)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  // inc and dec together cancel; never wrap in either direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != CNT_W'(MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full = (cnt == CNT_W'(MAX));

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-read-port register file with per-register pending-write scoreboard.
// Optional same-cycle writeback-to-read bypass enabled by defining RF_BYPASS_EN.
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter  int unsigned WORD_W       = WORD_W_DEF,
  parameter  int unsigned NREGS        = NREGS_DEF,
  parameter  int unsigned NREAD        = NREAD_DEF,
  parameter  int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  localparam int unsigned SEL_W        = $clog2(NREGS),
  localparam int unsigned CNT_W        = cnt_width(MAX_INFLIGHT)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREAD*SEL_W-1:0]  rsel,
  output logic [NREAD*WORD_W-1:0] rdat,
  output logic [NREAD-1:0]        rrdy,
  input  logic                    iss_en,
  input  logic [SEL_W-1:0]        iss_sel,
  output logic                    iss_full,
  input  logic                    WEN,
  input  logic [SEL_W-1:0]        wsel,
  input  logic [WORD_W-1:0]       wdat,
  output logic                    wb_err
);

  logic [WORD_W-1:0] rf   [NREGS];
  logic [CNT_W-1:0]  pend [NREGS];
  logic [NREGS-1:0]  inc;
  logic [NREGS-1:0]  dec;
  logic [NREGS-1:0]  full;
  logic              wb_hit;
  logic              iss_ok;

  // Issue acceptance; a same-register writeback frees the slot the issue needs.
  always_comb begin
    wb_hit   = WEN && (wsel != '0);
    iss_full = (iss_sel != '0) && full[iss_sel] && !(WEN && (wsel == iss_sel));
    iss_ok   = iss_en && (iss_sel != '0) && !iss_full;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    if (iss_ok) inc[iss_sel] = 1'b1;
    if (wb_hit) dec[wsel]    = 1'b1;
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_pend
    rf_pend_counter #(
      .MAX (MAX_INFLIGHT)
    ) u_cnt (
      .CLK  (CLK),
      .RST  (RST),
      .inc  (inc[r]),
      .dec  (dec[r]),
      .cnt  (pend[r]),
      .full (full[r])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else if (wb_hit) begin
      rf[wsel] <= wdat;
    end
  end

  // A writeback with nothing reserved is an error unless an issue to it lands on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_err <= 1'b0;
    end else if (wb_hit && (pend[wsel] == '0) && !(iss_en && (iss_sel == wsel))) begin
      wb_err <= 1'b1;
    end
  end

  always_comb begin
    rdat = '0;
    rrdy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rdat[i*WORD_W +: WORD_W] = rf[rsel[i*SEL_W +: SEL_W]];
      rrdy[i]                  = (pend[rsel[i*SEL_W +: SEL_W]] == '0);
`ifdef RF_BYPASS_EN
      if (WEN && (wsel == rsel[i*SEL_W +: SEL_W]) && (wsel != '0)) begin
        rdat[i*WORD_W +: WORD_W] = wdat;
        rrdy[i]                  = (pend[rsel[i*SEL_W +: SEL_W]] <= CNT_W'(1));
      end
`endif
      if (rsel[i*SEL_W +: SEL_W] == '0) begin
        rdat[i*WORD_W +: WORD_W] = '0;
        rrdy[i]                  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench for scoreboard_register_file: directed vector table, corner sequences, random vs model.
module tb_scoreboard_register_file;
  import scoreboard_register_file_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned N    = 32;
  localparam int unsigned NR   = 2;
  localparam int unsigned MAXI = 3;
  localparam int unsigned SW   = 5;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic [NR*SW-1:0] rsel;
  logic [NR*W-1:0]  rdat;
  logic [NR-1:0]    rrdy;
  logic             iss_en;
  logic [SW-1:0]    iss_sel;
  logic             iss_full;
  logic             WEN;
  logic [SW-1:0]    wsel;
  logic [W-1:0]     wdat;
  logic             wb_err;

  always #5 CLK = ~CLK;

  scoreboard_register_file dut (
    .CLK      (CLK),
    .RST      (RST),
    .rsel     (rsel),
    .rdat     (rdat),
    .rrdy     (rrdy),
    .iss_en   (iss_en),
    .iss_sel  (iss_sel),
    .iss_full (iss_full),
    .WEN      (WEN),
    .wsel     (wsel),
    .wdat     (wdat),
    .wb_err   (wb_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic ie, input logic [SW-1:0] is,
                       input logic we, input logic [SW-1:0] ws, input logic [W-1:0] wd,
                       input logic [SW-1:0] r0, input logic [SW-1:0] r1);
    RST = r; iss_en = ie; iss_sel = is; WEN = we; wsel = ws; wdat = wd;
    rsel = {r1, r0};
  endtask

  typedef struct {
    logic          rst;
    logic          ie;
    logic [SW-1:0] is;
    logic          we;
    logic [SW-1:0] ws;
    logic [W-1:0]  wd;
    logic [SW-1:0] r0;
    logic [SW-1:0] r1;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
    logic [1:0]    ey;
    logic          ef;
    logic          ee;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ie, logic [SW-1:0] is, logic we, logic [SW-1:0] ws,
                              logic [W-1:0] wd, logic [SW-1:0] r0, logic [SW-1:0] r1,
                              logic [W-1:0] e0, logic [W-1:0] e1, logic [1:0] ey, logic ef, logic ee);
    vec_t v;
    v.rst = rst; v.ie = ie; v.is = is; v.we = we; v.ws = ws; v.wd = wd;
    v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.ey = ey; v.ef = ef; v.ee = ee;
    return v;
  endfunction

  // Reference model: architectural register values, reservation counts, sticky error.
  logic [W-1:0] m_rf   [N];
  int           m_pend [N];
  logic         m_err;

  function automatic logic m_full();
    return (iss_sel != 0) && (m_pend[iss_sel] == MAXI) && !(WEN && (wsel == iss_sel));
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [SW-1:0] s);
    if (s == 0) return '0;
    if (BYP && WEN && (wsel == s)) return wdat;
    return m_rf[s];
  endfunction

  function automatic logic m_rdy(input logic [SW-1:0] s);
    if (s == 0) return 1'b1;
    if (BYP && WEN && (wsel == s)) return m_pend[s] <= 1;
    return m_pend[s] == 0;
  endfunction

  task automatic model_step();
    logic acc;
    logic wb;
    acc = iss_en && (iss_sel != 0) && !m_full();
    wb  = WEN && (wsel != 0);
    if (RST) begin
      for (int r = 0; r < N; r++) begin m_rf[r] = '0; m_pend[r] = 0; end
      m_err = 1'b0;
    end else begin
      if (wb) begin
        m_rf[wsel] = wdat;
        if (!(acc && (iss_sel == wsel))) begin
          if (m_pend[wsel] > 0) m_pend[wsel]--;
          else m_err = 1'b1;
        end
      end
      if (acc && !(wb && (wsel == iss_sel))) m_pend[iss_sel]++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 1, 5);
    #1;
    chk("reset rdat0", rdat[31:0], 32'h0);
    chk("reset rdat1", rdat[63:32], 32'h0);
    chk("reset rrdy", 32'(rrdy), 32'h3);
    chk("reset iss_full", 32'(iss_full), 32'h0);
    chk("reset wb_err", 32'(wb_err), 32'h0);

    //               rst ie is  we ws  wd            r0  r1  e0            e1     ey     ef ee
    vecs.push_back(mk(0, 0, 0,  1, 5,  32'hDEADBEEF, 0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            5,  0,  32'hDEADBEEF, 0,     2'b11, 0, 1));
    vecs.push_back(mk(1, 0, 0,  0, 0,  0,            5,  0,  32'hDEADBEEF, 0,     2'b11, 0, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            5,  5,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 0,  1, 0,  32'hFFFFFFFF, 0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 7,  0, 0,  0,            7,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 7,  0, 0,  0,            7,  0,  0,            0,     2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 7,  0, 0,  0,            7,  0,  0,            0,     2'b10, 0, 0));
    vecs.push_back(mk(0, 1, 7,  0, 0,  0,            7,  0,  0,            0,     2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 7,  0, 0,  0,            7,  0,  0,            0,     2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 7,  1, 7,  32'h71,       0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            7,  0,  32'h71,       0,     2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 7,  32'h72,       0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            7,  0,  32'h72,       0,     2'b10, 0, 0));
    vecs.push_back(mk(0, 0, 0,  1, 7,  32'h73,       0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            7,  7,  32'h73,       32'h73, 2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 9,  0, 0,  0,            0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 9,  0, 0,  0,            0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 9,  0, 0,  0,            0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 1, 9,  1, 9,  32'h99,       0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 9,  0, 0,  0,            9,  0,  32'h99,       0,     2'b10, 1, 0));
    vecs.push_back(mk(0, 0, 0,  1, 12, 32'hC0C0,     0,  0,  0,            0,     2'b11, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0,  0,            12, 0,  32'hC0C0,     0,     2'b11, 0, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge CLK);
      drive(vecs[k].rst, vecs[k].ie, vecs[k].is, vecs[k].we, vecs[k].ws, vecs[k].wd,
            vecs[k].r0, vecs[k].r1);
      #1;
      chk($sformatf("v%0d rdat0", k), rdat[31:0], vecs[k].e0);
      chk($sformatf("v%0d rdat1", k), rdat[63:32], vecs[k].e1);
      chk($sformatf("v%0d rrdy", k), 32'(rrdy), 32'(vecs[k].ey));
      chk($sformatf("v%0d iss_full", k), 32'(iss_full), 32'(vecs[k].ef));
      chk($sformatf("v%0d wb_err", k), 32'(wb_err), 32'(vecs[k].ee));
    end

    // Sticky error survives idle cycles.
    repeat (5) begin
      @(negedge CLK);
      drive(0, 0, 0, 0, 0, 0, 12, 0);
    end
    #1;
    chk("wb_err sticky", 32'(wb_err), 32'h1);

    // Writeback to a once-reserved register while port 1 reads it.
    @(negedge CLK);
    drive(0, 1, 3, 0, 0, 0, 0, 3);
    @(negedge CLK);
    drive(0, 0, 0, 1, 3, 32'h1234, 0, 3);
    #1;
    chk("bypass rdat1 same", rdat[63:32], BYP ? 32'h1234 : 32'h0);
    chk("bypass rrdy1 same", 32'(rrdy[1]), BYP ? 32'h1 : 32'h0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 3);
    #1;
    chk("bypass rdat1 next", rdat[63:32], 32'h1234);
    chk("bypass rrdy1 next", 32'(rrdy[1]), 32'h1);

    // Randomized traffic over a few registers so collisions are frequent.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      drive((c == 0) || ($urandom_range(0, 99) == 0),
            $urandom_range(0, 2) != 0, SW'($urandom_range(0, 7)),
            $urandom_range(0, 1) != 0, SW'($urandom_range(0, 7)), $urandom,
            SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)));
      #1;
      if (c > 0) begin
        chk($sformatf("rnd%0d rdat0", c), rdat[31:0], m_rd(rsel[SW-1:0]));
        chk($sformatf("rnd%0d rdat1", c), rdat[63:32], m_rd(rsel[2*SW-1:SW]));
        chk($sformatf("rnd%0d rrdy", c), 32'(rrdy), 32'({m_rdy(rsel[2*SW-1:SW]), m_rdy(rsel[SW-1:0])}));
        chk($sformatf("rnd%0d iss_full", c), 32'(iss_full), 32'(m_full()));
        chk($sformatf("rnd%0d wb_err", c), 32'(wb_err), 32'(m_err));
      end
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
